// File: rtl/imem_paged_loader_if.sv
// Fetch and program-load bus of the paged instruction memory.
// IMEM_BOUNDS_CHECK_EN adds the fetch_fault signal.
interface imem_paged_loader_if #(
   parameter int PID_W = 2
);
   logic [31:0]      pc;
   logic [PID_W-1:0] proc_id;
   logic             bios_end;
   logic             load_start;
   logic [PID_W-1:0] load_proc;
   logic             load_valid;
   logic [31:0]      load_data;
   logic             load_last;
   logic             load_ready;
   logic             load_busy;
   logic             load_done;
   logic             load_overflow;
   logic             bios_mode;
   logic [5:0]       opcode;
   logic [4:0]       rd;
   logic [4:0]       rs;
   logic [4:0]       rt;
   logic [15:0]      imediato;
   logic [25:0]      jump;
`ifdef IMEM_BOUNDS_CHECK_EN
   logic             fetch_fault;
`endif

   modport master (
      output pc, proc_id, bios_end, load_start, load_proc, load_valid, load_data, load_last,
      input  load_ready, load_busy, load_done, load_overflow, bios_mode,
             opcode, rd, rs, rt, imediato, jump
`ifdef IMEM_BOUNDS_CHECK_EN
      , input fetch_fault
`endif
   );

   modport slave (
      input  pc, proc_id, bios_end, load_start, load_proc, load_valid, load_data, load_last,
      output load_ready, load_busy, load_done, load_overflow, bios_mode,
             opcode, rd, rs, rt, imediato, jump
`ifdef IMEM_BOUNDS_CHECK_EN
      , output fetch_fault
`endif
   );
endinterface

// File: rtl/imem_paged_loader.sv
// Paged instruction memory: BIOS ROM, per-process blocks, HD stream loader and field decode.
// IMEM_BOUNDS_CHECK_EN: out-of-range fetches return NOP and raise fetch_fault.
//
// state | meaning
// IDLE  | waiting for load_start
// LOAD  | accepting and writing words into the selected block
// DRAIN | block full, accepting and dropping words until load_last
// DONE  | one-cycle load_done pulse
module imem_paged_loader #(
   parameter int BIOS_DEPTH = 128,
   parameter int NUM_PROC   = 4,
   parameter int BLOCK_SIZE = 200,
   parameter int PID_W      = 2
) (
   input logic                 clock,
   input logic                 reset,
   imem_paged_loader_if.slave  bus
);
   localparam int ARRAY = NUM_PROC * BLOCK_SIZE;
   localparam int AW    = $clog2(ARRAY);
   localparam int CW    = $clog2(BLOCK_SIZE);
   localparam int BW    = $clog2(BIOS_DEPTH);

   typedef enum logic [1:0] {IDLE, LOAD, DRAIN, DONE} state_t;

   state_t           state, state_nxt;
   logic [CW-1:0]    cursor, cursor_nxt;
   logic [PID_W-1:0] blk, blk_nxt;
   logic             overflow, overflow_nxt;
   logic             bios_mode;
   logic             we;
   logic [AW-1:0]    waddr;
   logic [31:0]      phys;
   logic [31:0]      instr;
   logic [31:0]      mem [ARRAY];
`ifdef IMEM_BOUNDS_CHECK_EN
   logic             fault;
`endif

   // Addresses 1..32 hold movi rN,0 so the BIOS zeroes the register file.
   function automatic logic [31:0] bios_rom(input logic [BW-1:0] a);
      if (a >= BW'(1) && a <= BW'(32))
         return {6'b011010, 5'(a - BW'(1)), 21'b0};
      return 32'b0;
   endfunction

   always_ff @(negedge clock or posedge reset) begin
      if (reset) begin
         state     <= IDLE;
         cursor    <= '0;
         blk       <= '0;
         overflow  <= 1'b0;
         bios_mode <= 1'b1;
      end else begin
         state    <= state_nxt;
         cursor   <= cursor_nxt;
         blk      <= blk_nxt;
         overflow <= overflow_nxt;
         if (bus.bios_end)
            bios_mode <= 1'b0;
      end
   end

   always_comb begin
      state_nxt    = state;
      cursor_nxt   = cursor;
      blk_nxt      = blk;
      overflow_nxt = overflow;
      we           = 1'b0;
      unique case (state)
         IDLE: begin
            if (bus.load_start && 32'(bus.load_proc) < 32'(NUM_PROC)) begin
               state_nxt    = LOAD;
               blk_nxt      = bus.load_proc;
               cursor_nxt   = '0;
               overflow_nxt = 1'b0;
            end
         end
         LOAD: begin
            if (bus.load_valid) begin
               we = 1'b1;
               if (bus.load_last)
                  state_nxt = DONE;
               else if (cursor == CW'(BLOCK_SIZE - 1))
                  state_nxt = DRAIN;
               if (cursor != CW'(BLOCK_SIZE - 1))
                  cursor_nxt = cursor + CW'(1);
            end
         end
         DRAIN: begin
            if (bus.load_valid) begin
               overflow_nxt = 1'b1;
               if (bus.load_last)
                  state_nxt = DONE;
            end
         end
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   assign waddr = AW'(32'(blk) * 32'(BLOCK_SIZE) + 32'(cursor));

   // Array is deliberately not reset: program images survive a processor reset.
   always_ff @(negedge clock) begin
      if (we)
         mem[waddr] <= bus.load_data;
   end

   assign phys = 32'(bus.proc_id) * 32'(BLOCK_SIZE) + bus.pc;

`ifdef IMEM_BOUNDS_CHECK_EN
   always_comb begin
      instr = '0;
      fault = 1'b0;
      if (bios_mode) begin
         if (bus.pc < 32'(BIOS_DEPTH))
            instr = bios_rom(BW'(bus.pc));
         else
            fault = 1'b1;
      end else if (bus.pc < 32'(BLOCK_SIZE) && 32'(bus.proc_id) < 32'(NUM_PROC)) begin
         instr = mem[AW'(phys)];
      end else begin
         fault = 1'b1;
      end
   end
   assign bus.fetch_fault = fault;
`else
   always_comb begin
      instr = '0;
      if (bios_mode) begin
         if (bus.pc < 32'(BIOS_DEPTH))
            instr = bios_rom(BW'(bus.pc));
      end else begin
         instr = mem[AW'(phys % 32'(ARRAY))];
      end
   end
`endif

   assign bus.load_ready    = (state == LOAD) || (state == DRAIN);
   assign bus.load_busy     = (state != IDLE);
   assign bus.load_done     = (state == DONE);
   assign bus.load_overflow = overflow;
   assign bus.bios_mode     = bios_mode;
   assign bus.opcode        = instr[31:26];
   assign bus.rd            = instr[25:21];
   assign bus.rs            = instr[20:16];
   assign bus.rt            = instr[15:11];
   assign bus.imediato      = {5'b0, instr[10:0]};
   assign bus.jump          = instr[25:0];
endmodule

// File: tb/tb_imem_paged_loader.sv
// Randomized bench for imem_paged_loader against a flat-array memory model.
module tb_imem_paged_loader;
   localparam int NP = 4;
   localparam int BS = 200;

   logic clock;
   logic reset;
   int   n_tests = 0;
   int   n_fail  = 0;

   logic [31:0] ref_mem [NP*BS];
   bit          ref_ok  [NP*BS];
   bit          model_bios;

   imem_paged_loader_if #(.PID_W(2)) bus ();

   imem_paged_loader #(
      .BIOS_DEPTH(128), .NUM_PROC(NP), .BLOCK_SIZE(BS), .PID_W(2)
   ) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic check_fetch(input string tag, input int pid, input int unsigned pcv);
      logic [31:0] exp;
      logic [31:0] got;
      bit          known;
      bit          exp_fault;
      longint      idx;
      bus.proc_id = 2'(pid);
      bus.pc      = pcv;
      #1;
      known     = 1'b1;
      exp       = 32'h0;
      exp_fault = 1'b0;
      if (model_bios) begin
         if (pcv >= 1 && pcv <= 32)
            exp = 32'(26) * 32'h0400_0000 + 32'(pcv - 1) * 32'h0020_0000;
         else if (pcv >= 128)
            exp_fault = 1'b1;
      end else begin
`ifdef IMEM_BOUNDS_CHECK_EN
         if (pcv >= BS || pid >= NP) begin
            exp_fault = 1'b1;
         end else begin
            idx   = longint'(pid) * BS + longint'(pcv);
            known = ref_ok[idx];
            exp   = ref_mem[idx];
         end
`else
         idx   = (longint'(pid) * BS + longint'(pcv)) % (NP * BS);
         known = ref_ok[idx];
         exp   = ref_mem[idx];
`endif
      end
      if (known) begin
         got = {bus.opcode, bus.rd, bus.rs, bus.rt, bus.imediato[10:0]};
         check_val({tag, " instr"}, got, exp);
         check_val({tag, " imm"}, {16'b0, bus.imediato}, {21'b0, exp[10:0]});
         check_val({tag, " jump"}, {6'b0, bus.jump}, {6'b0, exp[25:0]});
      end
`ifdef IMEM_BOUNDS_CHECK_EN
      check_val({tag, " fault"}, 32'(bus.fetch_fault), 32'(exp_fault));
`endif
   endtask

   // Streams n random words into block blk; gaps drop valid, optionally poking a stray load_start.
   task automatic load_prog(input int blk, input int n, input int gap_pct, input bit poke_start);
      logic [31:0] w;
      int i;
      @(posedge clock);
      bus.load_start = 1'b1;
      bus.load_proc  = 2'(blk);
      @(posedge clock);
      bus.load_start = 1'b0;
      i = 0;
      while (i < n) begin
         check_val("ready in load", 32'(bus.load_ready), 32'd1);
         if (int'($urandom_range(99)) < gap_pct) begin
            bus.load_valid = 1'b0;
            bus.load_data  = $urandom;
            bus.load_last  = 1'($urandom_range(1));
            if (poke_start) begin
               bus.load_start = 1'b1;
               bus.load_proc  = 2'(blk + 1);
            end
         end else begin
            w = $urandom;
            bus.load_start = 1'b0;
            bus.load_valid = 1'b1;
            bus.load_data  = w;
            bus.load_last  = (i == n - 1);
            if (i < BS) begin
               ref_mem[blk*BS + i] = w;
               ref_ok[blk*BS + i]  = 1'b1;
            end
            i++;
         end
         @(posedge clock);
      end
      bus.load_valid = 1'b0;
      bus.load_last  = 1'b0;
      bus.load_start = 1'b0;
      check_val("done pulse", 32'(bus.load_done), 32'd1);
      check_val("busy in done", 32'(bus.load_busy), 32'd1);
      check_val("ready in done", 32'(bus.load_ready), 32'd0);
      @(posedge clock);
      check_val("done cleared", 32'(bus.load_done), 32'd0);
      check_val("busy cleared", 32'(bus.load_busy), 32'd0);
      check_val("overflow", 32'(bus.load_overflow), 32'(n > BS));
   endtask

   task automatic leave_bios();
      @(posedge clock);
      bus.bios_end = 1'b1;
      @(posedge clock);
      bus.bios_end = 1'b0;
      model_bios   = 1'b0;
      check_val("bios_mode cleared", 32'(bus.bios_mode), 32'd0);
   endtask

   initial begin
      logic [31:0] w;
      reset          = 1'b1;
      model_bios     = 1'b1;
      bus.pc         = 32'd5;
      bus.proc_id    = '0;
      bus.bios_end   = 1'b0;
      bus.load_start = 1'b0;
      bus.load_proc  = '0;
      bus.load_valid = 1'b0;
      bus.load_data  = '0;
      bus.load_last  = 1'b0;
      repeat (3) @(posedge clock);
      check_val("reset bios_mode", 32'(bus.bios_mode), 32'd1);
      check_val("reset busy", 32'(bus.load_busy), 32'd0);
      check_val("reset ready", 32'(bus.load_ready), 32'd0);
      check_val("reset done", 32'(bus.load_done), 32'd0);
      check_val("reset overflow", 32'(bus.load_overflow), 32'd0);
      reset = 1'b0;
      @(posedge clock);

      check_val("bios pc5 opcode", 32'(bus.opcode), 32'b011010);
      check_val("bios pc5 rd", 32'(bus.rd), 32'd4);
      check_val("bios pc5 rs", 32'(bus.rs), 32'd0);
      check_val("bios pc5 rt", 32'(bus.rt), 32'd0);
      check_val("bios pc5 imm", 32'(bus.imediato), 32'd0);
      check_fetch("bios pc0", 0, 0);
      check_fetch("bios pc1", 0, 1);
      check_fetch("bios pc32", 0, 32);
      check_fetch("bios pc33", 0, 33);
      check_fetch("bios pc127", 0, 127);
      check_fetch("bios pc128", 0, 128);
      repeat (16) check_fetch("bios rand", int'($urandom_range(3)), $urandom_range(300));

      load_prog(1, 10, 25, 1'b1);
      check_val("still bios", 32'(bus.bios_mode), 32'd1);
      leave_bios();

      load_prog(2, 3, 0, 1'b0);
      check_fetch("blk2 pc0", 2, 0);
      check_fetch("blk2 pc1", 2, 1);
      check_fetch("blk2 pc2", 2, 2);
      check_fetch("blk1 pc0", 1, 0);

      load_prog(1, 205, 15, 1'b0);
      check_fetch("blk1 pc0 ovf", 1, 0);
      check_fetch("blk1 pc199 ovf", 1, 199);
      check_fetch("blk2 pc0 kept", 2, 0);
      repeat (10) check_fetch("blk1 rand", 1, $urandom_range(BS - 1));

      load_prog(3, 200, 10, 1'b1);
      check_fetch("blk3 pc199", 3, 199);
      check_fetch("blk1 pc200", 1, 200);
      check_fetch("blk1 pc199", 1, 199);

      load_prog(0, 20, 40, 1'b1);
      repeat (5) load_prog(int'($urandom_range(3)), int'($urandom_range(1, 40)), 30, 1'b1);
      repeat (40) check_fetch("main rand", int'($urandom_range(3)), $urandom_range(2*BS - 1));

      // Reset while the third of five words is on the bus.
      @(posedge clock);
      bus.load_start = 1'b1;
      bus.load_proc  = 2'd0;
      @(posedge clock);
      bus.load_start = 1'b0;
      for (int k = 0; k < 2; k++) begin
         w = $urandom;
         bus.load_valid = 1'b1;
         bus.load_data  = w;
         bus.load_last  = 1'b0;
         ref_mem[k] = w;
         ref_ok[k]  = 1'b1;
         @(posedge clock);
      end
      bus.load_data = $urandom;
      reset = 1'b1;
      #1;
      model_bios = 1'b1;
      check_val("midload busy", 32'(bus.load_busy), 32'd0);
      check_val("midload ready", 32'(bus.load_ready), 32'd0);
      check_val("midload bios_mode", 32'(bus.bios_mode), 32'd1);
      @(posedge clock);
      bus.load_valid = 1'b0;
      reset = 1'b0;
      leave_bios();
      check_fetch("midload w0", 0, 0);
      check_fetch("midload w1", 0, 1);
      check_fetch("midload w2", 0, 2);
      load_prog(0, 4, 20, 1'b0);
      for (int k = 0; k < 4; k++) check_fetch("reload", 0, k);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
